// File: rtl/hazard_scoreboard_if.sv
// Pipeline-side bundle of the hazard scoreboard: ID-stage operands, redirect/freeze
// requests in, and pipeline-register enables/flushes back out.
interface hazard_scoreboard_if #(
  parameter int REG_ADDR_W = 5,
  parameter int MAX_LAT    = 7
);
  localparam int LAT_W = $clog2(MAX_LAT + 1);

  logic                  id_valid_i;
  logic [REG_ADDR_W-1:0] rs1_addr_id_i;
  logic [REG_ADDR_W-1:0] rs2_addr_id_i;
  logic                  rs1_use_i;
  logic                  rs2_use_i;
  logic [REG_ADDR_W-1:0] rd_addr_id_i;
  logic                  rd_we_id_i;
  logic [LAT_W-1:0]      lat_id_i;
  logic                  flush_req_i;
  logic                  freeze_i;

  logic                  pc_write_en_o;
  logic                  if_id_write_en_o;
  logic                  if_id_flush_o;
  logic                  id_ex_write_en_o;
  logic                  id_ex_flush_o;
  logic                  issue_o;
  logic                  busy_o;

  modport master (
    output id_valid_i, rs1_addr_id_i, rs2_addr_id_i, rs1_use_i, rs2_use_i,
           rd_addr_id_i, rd_we_id_i, lat_id_i, flush_req_i, freeze_i,
    input  pc_write_en_o, if_id_write_en_o, if_id_flush_o, id_ex_write_en_o,
           id_ex_flush_o, issue_o, busy_o
  );

  modport slave (
    input  id_valid_i, rs1_addr_id_i, rs2_addr_id_i, rs1_use_i, rs2_use_i,
           rd_addr_id_i, rd_we_id_i, lat_id_i, flush_req_i, freeze_i,
    output pc_write_en_o, if_id_write_en_o, if_id_flush_o, id_ex_write_en_o,
           id_ex_flush_o, issue_o, busy_o
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register pending-latency scoreboard driving PC / IF/ID / ID/EX control.
// Optional HAZARD_STATS_EN adds stall and flush cycle counters.
module hazard_scoreboard #(
  parameter int REG_ADDR_W       = 5,
  parameter int MAX_LAT          = 7,
  parameter int REDIRECT_BUBBLES = 0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  hazard_scoreboard_if.slave  hz
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]         stall_cnt_o,
  output logic [31:0]         flush_cnt_o
`endif
);
  localparam int NREG   = 2 ** REG_ADDR_W;
  localparam int LAT_W  = $clog2(MAX_LAT + 1);
  localparam int SCNT_W = (REDIRECT_BUBBLES > 0) ? $clog2(REDIRECT_BUBBLES + 1) : 1;

  typedef logic [LAT_W-1:0] lat_t;
  typedef enum logic [2:0] {
    MODE_RESET, MODE_FREEZE, MODE_REDIRECT, MODE_STALL, MODE_RUN
  } mode_e;

  lat_t              pend [NREG];
  logic [SCNT_W-1:0] stretch_cnt;
  lat_t              lat_sat;
  logic              raw, waw, stretch, issue, busy;
  mode_e             mode;

  generate
    if (MAX_LAT + 1 == 2 ** LAT_W) begin : g_lat_full
      assign lat_sat = hz.lat_id_i;
    end else begin : g_lat_clip
      assign lat_sat = (hz.lat_id_i > LAT_W'(MAX_LAT)) ? LAT_W'(MAX_LAT) : hz.lat_id_i;
    end
  endgenerate

  // pend[0] is never loaded, so reads of x0 never see a hazard.
  assign raw = hz.id_valid_i &&
               ((hz.rs1_use_i && pend[hz.rs1_addr_id_i] != '0) ||
                (hz.rs2_use_i && pend[hz.rs2_addr_id_i] != '0));
  assign waw = hz.id_valid_i && hz.rd_we_id_i && hz.rd_addr_id_i != '0 &&
               pend[hz.rd_addr_id_i] > lat_sat;
  assign stretch = stretch_cnt != '0;

  always_comb begin
    if (rst_i)                         mode = MODE_RESET;
    else if (hz.freeze_i)              mode = MODE_FREEZE;
    else if (hz.flush_req_i || stretch) mode = MODE_REDIRECT;
    else if (raw || waw)               mode = MODE_STALL;
    else                               mode = MODE_RUN;
  end

  assign issue = (mode == MODE_RUN) && hz.id_valid_i;

  // NOTE: every output gets a default before the case so no path infers a latch.
  always_comb begin
    hz.pc_write_en_o    = 1'b1;
    hz.if_id_write_en_o = 1'b1;
    hz.id_ex_write_en_o = 1'b1;
    hz.if_id_flush_o    = 1'b0;
    hz.id_ex_flush_o    = 1'b0;
    hz.issue_o          = issue;
    case (mode)
      MODE_RESET: begin
        hz.pc_write_en_o    = 1'b0;
        hz.if_id_write_en_o = 1'b0;
        hz.id_ex_write_en_o = 1'b0;
        hz.if_id_flush_o    = 1'b1;
        hz.id_ex_flush_o    = 1'b1;
      end
      MODE_FREEZE: begin
        hz.pc_write_en_o    = 1'b0;
        hz.if_id_write_en_o = 1'b0;
        hz.id_ex_write_en_o = 1'b0;
      end
      MODE_REDIRECT: begin
        hz.if_id_flush_o = 1'b1;
        hz.id_ex_flush_o = 1'b1;
      end
      MODE_STALL: begin
        hz.pc_write_en_o    = 1'b0;
        hz.if_id_write_en_o = 1'b0;
        hz.id_ex_flush_o    = 1'b1;
      end
      default: hz.id_ex_flush_o = ~hz.id_valid_i;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      if (pend[r] != '0) busy = 1'b1;
    end
  end
  assign hz.busy_o = busy && !rst_i;

  // NOTE: pend is a flop array, not RAM, so it is cleared by reset in one cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < NREG; r++) pend[r] <= '0;
      stretch_cnt <= '0;
    end else if (!hz.freeze_i) begin
      for (int r = 1; r < NREG; r++) begin
        if (issue && hz.rd_we_id_i && hz.rd_addr_id_i == REG_ADDR_W'(r))
          pend[r] <= lat_sat;
        else if (pend[r] != '0)
          pend[r] <= pend[r] - LAT_W'(1);
      end
      pend[0] <= '0;
      if (hz.flush_req_i)
        stretch_cnt <= SCNT_W'(REDIRECT_BUBBLES);
      else if (stretch)
        stretch_cnt <= stretch_cnt - SCNT_W'(1);
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (mode == MODE_STALL)    stall_cnt_o <= stall_cnt_o + 32'd1;
      if (mode == MODE_REDIRECT) flush_cnt_o <= flush_cnt_o + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed test-plan scenarios followed by random traffic, all checked every
// cycle against a ready-time model of the scoreboard.
module tb_hazard_scoreboard;
  localparam int RB = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.REG_ADDR_W(5), .MAX_LAT(7)) hz ();

  hazard_scoreboard #(
    .REG_ADDR_W(5), .MAX_LAT(7), .REDIRECT_BUBBLES(RB)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .hz    (hz)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Model: a register is ready once the count of unfrozen cycles reaches ready_at.
  longint now;
  longint ready_at [32];
  longint flush_until;
  logic   e_pcw, e_ifw, e_idw, e_iff, e_idf, e_iss, e_busy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic longint rem(input int r);
    return (r != 0 && ready_at[r] > now) ? ready_at[r] - now : 64'sd0;
  endfunction

  task automatic drive(input logic r, input logic fz, input logic fl, input logic v,
                       input logic [4:0] a1, input logic u1,
                       input logic [4:0] a2, input logic u2,
                       input logic [4:0] d, input logic w, input logic [2:0] l);
    rst              = r;
    hz.freeze_i      = fz;
    hz.flush_req_i   = fl;
    hz.id_valid_i    = v;
    hz.rs1_addr_id_i = a1;
    hz.rs1_use_i     = u1;
    hz.rs2_addr_id_i = a2;
    hz.rs2_use_i     = u2;
    hz.rd_addr_id_i  = d;
    hz.rd_we_id_i    = w;
    hz.lat_id_i      = l;
    #2;
  endtask

  task automatic model_check();
    logic raw, waw, redirect;
    e_busy = 1'b0;
    for (int r = 1; r < 32; r++) if (rem(r) != 0) e_busy = 1'b1;
    raw = hz.id_valid_i &&
          ((hz.rs1_use_i && rem(int'(hz.rs1_addr_id_i)) != 0) ||
           (hz.rs2_use_i && rem(int'(hz.rs2_addr_id_i)) != 0));
    waw = hz.id_valid_i && hz.rd_we_id_i && hz.rd_addr_id_i != 5'd0 &&
          rem(int'(hz.rd_addr_id_i)) > longint'(hz.lat_id_i);
    redirect = hz.flush_req_i || (now <= flush_until);
    if (rst) begin
      {e_pcw, e_ifw, e_idw, e_iff, e_idf, e_iss} = 6'b000110;
      e_busy = 1'b0;
    end else if (hz.freeze_i)  {e_pcw, e_ifw, e_idw, e_iff, e_idf, e_iss} = 6'b000000;
    else if (redirect)         {e_pcw, e_ifw, e_idw, e_iff, e_idf, e_iss} = 6'b111110;
    else if (raw || waw)       {e_pcw, e_ifw, e_idw, e_iff, e_idf, e_iss} = 6'b001010;
    else {e_pcw, e_ifw, e_idw, e_iff, e_idf, e_iss} =
      {3'b111, 1'b0, !hz.id_valid_i, hz.id_valid_i};
    check("pc_write_en",    hz.pc_write_en_o,    e_pcw);
    check("if_id_write_en", hz.if_id_write_en_o, e_ifw);
    check("id_ex_write_en", hz.id_ex_write_en_o, e_idw);
    check("if_id_flush",    hz.if_id_flush_o,    e_iff);
    check("id_ex_flush",    hz.id_ex_flush_o,    e_idf);
    check("issue",          hz.issue_o,          e_iss);
    check("busy",           hz.busy_o,           e_busy);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int r = 0; r < 32; r++) ready_at[r] = 0;
      flush_until = -1;
    end else if (!hz.freeze_i) begin
      if (hz.flush_req_i) flush_until = now + RB;
      if (e_iss && hz.rd_we_id_i && hz.rd_addr_id_i != 5'd0)
        ready_at[hz.rd_addr_id_i] = now + 1 + longint'(hz.lat_id_i);
      now++;
    end
    #1;
  endtask

  initial begin
    now = 0;
    flush_until = -1;
    for (int r = 0; r < 32; r++) ready_at[r] = 0;

    // Reset
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); model_check();
    check("rst_if_id_flush", hz.if_id_flush_o, 1);
    check("rst_busy", hz.busy_o, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); model_check(); tick();

    // Load x5 then add x6,x5,x1: one stall cycle
    drive(0, 0, 0, 1, 0, 0, 0, 0, 5, 1, 1); model_check();
    check("load_issue", hz.issue_o, 1);
    tick();
    drive(0, 0, 0, 1, 5, 1, 1, 1, 6, 1, 0); model_check();
    check("load_use_pc_hold", hz.pc_write_en_o, 0);
    check("load_use_bubble", hz.id_ex_flush_o, 1);
    tick();
    drive(0, 0, 0, 1, 5, 1, 1, 1, 6, 1, 0); model_check();
    check("load_use_issue", hz.issue_o, 1);
    tick();

    // Divide x7 lat 5 then dependent: five stall cycles
    drive(0, 0, 0, 1, 1, 1, 2, 1, 7, 1, 5); model_check(); tick();
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 1, 7, 1, 0, 0, 9, 1, 0); model_check();
      check("div_dep_stall", hz.issue_o, 0);
      check("div_busy", hz.busy_o, 1);
      tick();
    end
    drive(0, 0, 0, 1, 7, 1, 0, 0, 9, 1, 0); model_check();
    check("div_dep_issue", hz.issue_o, 1);
    check("div_busy_clear", hz.busy_o, 0);
    tick();

    // WAW: divide x8, independent ALU op, then ALU write to x8
    drive(0, 0, 0, 1, 1, 1, 2, 1, 8, 1, 5); model_check(); tick();
    drive(0, 0, 0, 1, 1, 1, 2, 1, 11, 1, 0); model_check();
    check("indep_alu_issue", hz.issue_o, 1);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, 1, 1, 2, 1, 8, 1, 0); model_check();
      check("waw_stall", hz.issue_o, 0);
      tick();
    end
    drive(0, 0, 0, 1, 1, 1, 2, 1, 8, 1, 0); model_check();
    check("waw_issue", hz.issue_o, 1);
    tick();

    // Flush on top of a load-use stall, stretched by RB cycles
    drive(0, 0, 0, 1, 0, 0, 0, 0, 5, 1, 1); model_check(); tick();
    drive(0, 0, 1, 1, 5, 1, 0, 0, 6, 1, 0); model_check();
    check("flush_pc_we", hz.pc_write_en_o, 1);
    check("flush_if_id", hz.if_id_flush_o, 1);
    check("flush_no_issue", hz.issue_o, 0);
    tick();
    for (int i = 0; i < RB; i++) begin
      drive(0, 0, 0, 1, 5, 1, 0, 0, 6, 1, 0); model_check();
      check("stretch_if_id", hz.if_id_flush_o, 1);
      tick();
    end
    drive(0, 0, 0, 1, 5, 1, 0, 0, 6, 1, 0); model_check();
    check("stretch_end", hz.if_id_flush_o, 0);
    check("after_stretch_issue", hz.issue_o, 1);
    tick();

    // Freeze for four cycles during a lat-3 countdown (flush ignored while frozen)
    drive(0, 0, 0, 1, 0, 0, 0, 0, 12, 1, 3); model_check(); tick();
    drive(0, 0, 0, 1, 12, 1, 0, 0, 13, 1, 0); model_check();
    check("pre_freeze_stall", hz.issue_o, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, (i == 1), 1, 12, 1, 0, 0, 13, 1, 0); model_check();
      check("freeze_pc_we", hz.pc_write_en_o, 0);
      check("freeze_id_ex_we", hz.id_ex_write_en_o, 0);
      check("freeze_if_id_flush", hz.if_id_flush_o, 0);
      check("freeze_busy", hz.busy_o, 1);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 1, 12, 1, 0, 0, 13, 1, 0); model_check();
      check("post_freeze_stall", hz.issue_o, 0);
      tick();
    end
    drive(0, 0, 0, 1, 12, 1, 0, 0, 13, 1, 0); model_check();
    check("post_freeze_issue", hz.issue_o, 1);
    tick();

    // Write to x0 then read x0: never a hazard
    drive(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 7); model_check(); tick();
    drive(0, 0, 0, 1, 0, 1, 0, 1, 14, 1, 0); model_check();
    check("x0_no_stall", hz.issue_o, 1);
    check("x0_not_busy", hz.busy_o, 0);
    tick();

    // Reset mid-countdown
    drive(0, 0, 0, 1, 0, 0, 0, 0, 13, 1, 3); model_check(); tick();
    drive(1, 0, 0, 1, 13, 1, 0, 0, 15, 1, 0); model_check();
    check("rst_mid_pc_we", hz.pc_write_en_o, 0);
    check("rst_mid_id_ex_flush", hz.id_ex_flush_o, 1);
    check("rst_mid_issue", hz.issue_o, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); model_check();
    check("post_rst_busy", hz.busy_o, 0);
    tick();

    // Random traffic over a small register window to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(99) == 0, $urandom_range(9) == 0, $urandom_range(11) == 0,
            $urandom_range(4) != 0,
            5'($urandom_range(7)), 1'($urandom),
            5'($urandom_range(7)), 1'($urandom),
            5'($urandom_range(7)), 1'($urandom),
            3'($urandom_range(7)));
      model_check();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
